mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and select sequencer for the 4:1 dataflow mux (mux_c).
- Four requesters compete for the mux output. The block registers a one-hot grant and drives the mux selects (sel[1] -> s1, sel[0] -> s0).
- Grants are break-before-make: one idle cycle sits between owners so the mux output never switches mid-transfer.

Parameters:
- HOLD_MAX, 8, maximum consecutive grant cycles per owner (used only when MUX_ARB_TIMEOUT_EN is defined); legal range 2..(2^CNT_W).
- CNT_W, 4, width of hold_cnt.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request vector; req[i] high = requester i wants the mux.
- grant  output  4  registered one-hot grant, or 0 when idle.
- sel  output  2  registered mux select, binary index of the current or last owner.
- active  output  1  high while grant != 0.
- hold_cnt  output  CNT_W  cycles the current owner has held the grant, 0-based.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (async, rst_n low, no clock needed):
  - grant=0, sel=2'b00, active=0, hold_cnt=0, timeout=0, state=IDLE.
  - Internal last-owner pointer=3, so requester 0 has top priority after reset.
- States: IDLE and GRANT. All outputs are registered.
- IDLE:
  - If req != 0, the winner is the first set bit scanning upward from (last+1) mod 4, wrapping 3->0.
  - At the next edge: grant=onehot(winner), sel=winner, active=1, hold_cnt=0, last=winner, state=GRANT.
  - If req == 0, stay in IDLE. sel holds its previous value; grant stays 0.
- GRANT:
  - Each cycle with req[owner]=1: hold grant; hold_cnt increments and saturates at 2^CNT_W-1.
  - req[owner]=0 sampled at edge N: at edge N+1 grant=0, active=0, hold_cnt=0, state=IDLE, sel unchanged.
  - Earliest new grant is at edge N+2. This gives the mandatory one-cycle gap.
  - Requests from non-owners during GRANT are ignored and never preempt the owner.
- Latency: request to grant = 1 cycle from IDLE. Owner release to next grant = 2 cycles.
- Fairness: with all four requesting continuously and each owner releasing, grant order is 0,1,2,3,0,...
- Simultaneous owner-release plus new requests: release takes effect first; arbitration happens in the following IDLE cycle using the updated last pointer.
- An owner that drops and re-raises req in consecutive cycles gets lowest priority in the next arbitration.
- Reset mid-GRANT: outputs clear immediately; any in-flight hold is lost.

Optional Feature:
- Macro: MUX_ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt == HOLD_MAX-1 and req[owner] is still 1, the grant is revoked at the next edge: grant=0, state=IDLE, timeout=1 for exactly that cycle, last=owner.
  - If the owner is the sole requester, it is re-granted after the gap.
- Undefined:
  - No forced release; an owner holds indefinitely.
  - timeout is tied to 0. hold_cnt still counts and saturates.

Test Plan:
1. rst_n=0 with req=4'b1111 and clk running -> grant=0, sel=00, active=0, timeout=0 throughout. Release rst_n -> one edge later grant=0001, sel=00.
2. req=4'b0110 from IDLE (last=3) -> grant=0010, sel=01. Drop req[1] -> next edge grant=0000 -> following edge grant=0100, sel=10.
3. req=4'b1111 held; each owner drops req for one cycle after 2 grant cycles -> grant sequence 0001,0010,0100,1000,0001, with exactly one zero-grant cycle between owners.
4. MUX_ARB_TIMEOUT_EN, HOLD_MAX=8, req=4'b1001 held -> grant=0001 for 8 cycles (hold_cnt 0..7), timeout=1 for one cycle with grant=0, then grant=1000, sel=11.
5. Macro undefined, req=4'b0001 held 50 cycles -> grant=0001 all 50 cycles, hold_cnt saturates at 15, timeout never asserts.
6. Async rst_n pulse mid-GRANT (grant=0100, between clock edges) -> grant, sel, active, hold_cnt clear immediately. After release with req=4'b0101 -> grant=0001.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the 4:1 mux requesters and mux_rr_arbiter.
interface mux_rr_arbiter_if #(
  parameter int unsigned CNT_W = 4
);
  logic [3:0]       req;
  logic [3:0]       grant;
  logic [1:0]       sel;
  logic             active;
  logic [CNT_W-1:0] hold_cnt;
  logic             timeout;

  modport master (
    output req,
    input  grant, sel, active, hold_cnt, timeout
  );

  modport slave (
    input  req,
    output grant, sel, active, hold_cnt, timeout
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Break-before-make round-robin arbiter driving the mux_c selects.
// Optional forced release after HOLD_MAX cycles: define MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_rr_arbiter_if.slave  bus
);

`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_n;
  logic [3:0]       grant_q, grant_n;
  logic [1:0]       sel_q, sel_n;
  logic             active_q, active_n;
  logic [CNT_W-1:0] hold_q, hold_n;
  logic             timeout_q, timeout_n;
  logic [1:0]       last_q, last_n;

  logic [1:0]       win, cand;
  logic             win_ok;

  // First requester strictly after the last owner, wrapping; last owner is checked last.
  always_comb begin
    win    = last_q;
    win_ok = 1'b0;
    cand   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!win_ok && bus.req[cand]) begin
        win    = cand;
        win_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state_q;
    grant_n   = grant_q;
    sel_n     = sel_q;
    active_n  = active_q;
    hold_n    = hold_q;
    timeout_n = 1'b0;
    last_n    = last_q;
    unique case (state_q)
      IDLE: begin
        if (win_ok) begin
          state_n  = GRANT;
          grant_n  = 4'b0001 << win;
          sel_n    = win;
          active_n = 1'b1;
          hold_n   = '0;
          last_n   = win;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q]) begin
          state_n  = IDLE;
          grant_n  = '0;
          active_n = 1'b0;
          hold_n   = '0;
        end else if (TIMEOUT_EN && hold_q == HOLD_LAST) begin
          state_n   = IDLE;
          grant_n   = '0;
          active_n  = 1'b0;
          hold_n    = '0;
          timeout_n = 1'b1;
        end else if (hold_q != '1) begin
          hold_n = hold_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      active_q  <= 1'b0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
      last_q    <= 2'd3;
    end else begin
      state_q   <= state_n;
      grant_q   <= grant_n;
      sel_q     <= sel_n;
      active_q  <= active_n;
      hold_q    <= hold_n;
      timeout_q <= timeout_n;
      last_q    <= last_n;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.sel      = sel_q;
  assign bus.active   = active_q;
  assign bus.hold_cnt = hold_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (default or MUX_ARB_TIMEOUT_EN build).
module tb_mux_rr_arbiter;
  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  mux_rr_arbiter_if #(.CNT_W(CNT_W)) bus ();

  mux_rr_arbiter #(.HOLD_MAX(8), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r);
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = r;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bus.grant !== 4'b0000 || bus.sel !== 2'b00 || bus.active !== 1'b0 ||
          bus.timeout !== 1'b0 || bus.hold_cnt !== 4'd0) begin
        fails++;
        $display("FAIL reset_hold: grant=%b sel=%b active=%b timeout=%b hold=%0d, want 0000/00/0/0/0",
                 bus.grant, bus.sel, bus.active, bus.timeout, bus.hold_cnt);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    tests++;
    if (bus.grant !== 4'b0001 || bus.sel !== 2'b00 || bus.active !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_grant: grant=%b sel=%b active=%b, want 0001/00/1",
               bus.grant, bus.sel, bus.active);
    end
  endtask

  task automatic test_basic_grant();
    do_reset(4'b0000);
    bus.req = 4'b0110;
    step();
    tests++;
    if (bus.grant !== 4'b0010 || bus.sel !== 2'b01) begin
      fails++;
      $display("FAIL basic_grant: grant=%b sel=%b, want 0010/01", bus.grant, bus.sel);
    end
    bus.req = 4'b0100;
    step();
    tests++;
    if (bus.grant !== 4'b0000 || bus.active !== 1'b0 || bus.sel !== 2'b01) begin
      fails++;
      $display("FAIL basic_gap: grant=%b active=%b sel=%b, want 0000/0/01",
               bus.grant, bus.active, bus.sel);
    end
    step();
    tests++;
    if (bus.grant !== 4'b0100 || bus.sel !== 2'b10) begin
      fails++;
      $display("FAIL basic_next: grant=%b sel=%b, want 0100/10", bus.grant, bus.sel);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset(4'b0000);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      step();
      tests++;
      if (bus.grant !== exp_g || bus.hold_cnt !== 4'd0 || bus.sel !== 2'(k % 4)) begin
        fails++;
        $display("FAIL rr_grant%0d: grant=%b sel=%b hold=%0d, want %b/%0d/0",
                 k, bus.grant, bus.sel, bus.hold_cnt, exp_g, k % 4);
      end
      step();
      tests++;
      if (bus.grant !== exp_g || bus.hold_cnt !== 4'd1) begin
        fails++;
        $display("FAIL rr_hold%0d: grant=%b hold=%0d, want %b/1", k, bus.grant, bus.hold_cnt, exp_g);
      end
      bus.req = 4'b1111 & ~exp_g;
      step();
      tests++;
      if (bus.grant !== 4'b0000 || bus.active !== 1'b0) begin
        fails++;
        $display("FAIL rr_gap%0d: grant=%b active=%b, want 0000/0", k, bus.grant, bus.active);
      end
      bus.req = 4'b1111;
    end
  endtask

`ifdef MUX_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset(4'b0000);
    bus.req = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      step();
      tests++;
      if (bus.grant !== 4'b0001 || bus.hold_cnt !== 4'(i) || bus.timeout !== 1'b0) begin
        fails++;
        $display("FAIL to_hold%0d: grant=%b hold=%0d timeout=%b, want 0001/%0d/0",
                 i, bus.grant, bus.hold_cnt, bus.timeout, i);
      end
    end
    step();
    tests++;
    if (bus.grant !== 4'b0000 || bus.timeout !== 1'b1 || bus.active !== 1'b0) begin
      fails++;
      $display("FAIL to_revoke: grant=%b timeout=%b active=%b, want 0000/1/0",
               bus.grant, bus.timeout, bus.active);
    end
    step();
    tests++;
    if (bus.grant !== 4'b1000 || bus.sel !== 2'b11 || bus.timeout !== 1'b0) begin
      fails++;
      $display("FAIL to_next: grant=%b sel=%b timeout=%b, want 1000/11/0",
               bus.grant, bus.sel, bus.timeout);
    end
  endtask
`else
  task automatic test_saturate();
    logic [3:0] exp_h;
    do_reset(4'b0000);
    bus.req = 4'b0001;
    for (int i = 0; i < 50; i++) begin
      exp_h = (i > 15) ? 4'd15 : 4'(i);
      step();
      tests++;
      if (bus.grant !== 4'b0001 || bus.hold_cnt !== exp_h || bus.timeout !== 1'b0) begin
        fails++;
        $display("FAIL sat_cycle%0d: grant=%b hold=%0d timeout=%b, want 0001/%0d/0",
                 i, bus.grant, bus.hold_cnt, bus.timeout, exp_h);
      end
    end
  endtask
`endif

  task automatic test_async_reset();
    do_reset(4'b0000);
    bus.req = 4'b0100;
    step();
    step();
    tests++;
    if (bus.grant !== 4'b0100 || bus.hold_cnt !== 4'd1) begin
      fails++;
      $display("FAIL ar_setup: grant=%b hold=%0d, want 0100/1", bus.grant, bus.hold_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.grant !== 4'b0000 || bus.sel !== 2'b00 || bus.active !== 1'b0 || bus.hold_cnt !== 4'd0) begin
      fails++;
      $display("FAIL ar_clear: grant=%b sel=%b active=%b hold=%0d, want 0000/00/0/0",
               bus.grant, bus.sel, bus.active, bus.hold_cnt);
    end
    bus.req = 4'b0101;
    #1;
    rst_n = 1'b1;
    step();
    tests++;
    if (bus.grant !== 4'b0001 || bus.sel !== 2'b00) begin
      fails++;
      $display("FAIL ar_regrant: grant=%b sel=%b, want 0001/00", bus.grant, bus.sel);
    end
  endtask

  initial begin
    bus.req = 4'b0000;
    test_reset();
    test_basic_grant();
    test_round_robin();
`ifdef MUX_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_saturate();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
